// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bus controller: RV32I load/store
// encodings, controller states, MMIO register offsets and lane helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    localparam logic [31:0] MMIO_CYCLES = 32'd0;
    localparam logic [31:0] MMIO_STORES = 32'd4;
    localparam logic [31:0] MMIO_LEDS   = 32'd8;
    localparam logic [31:0] MMIO_SPAN   = 32'd12;

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic m;
        m = 1'b0;
        case (f3[1:0])
            2'b01:   m = off[0];
            2'b10:   m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bus_ctrl_load_align.sv
// Load data alignment: picks the byte/halfword addressed by off_i out of a
// RAM word and sign- or zero-extends it according to the load funct3.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// M-stage data memory controller: stalls the pipeline across synchronous RAM
// accesses with wait states, and serves a small zero-latency MMIO window.
module dmem_bus_ctrl
    import dmem_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_0400
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    output logic              mem_we_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [7:0]        leds_o
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [2:0]        wait_q, wait_d;
    logic [31:0]       cyc_q, stc_q;
    logic [7:0]        leds_q;
    logic [ADDR_W+1:0] addr_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;

    logic [31:0] mmio_off, mmio_rd, ld_data;
    logic        is_mmio, misal, start_ram, mmio_acc;

    assign mmio_off  = addr_i - MMIO_BASE;
    assign is_mmio   = (addr_i >= MMIO_BASE) && (mmio_off < MMIO_SPAN);
    assign misal     = misaligned(funct3_i, addr_i[1:0]);
    assign start_ram = (state_q == IDLE) && req_i && !misal && !is_mmio;
    assign mmio_acc  = (state_q == IDLE) && req_i && !misal && is_mmio;

    always_comb begin
        mmio_rd = 32'h0;
        if (mmio_off == MMIO_CYCLES)      mmio_rd = cyc_q;
        else if (mmio_off == MMIO_STORES) mmio_rd = stc_q;
        else if (mmio_off == MMIO_LEDS)   mmio_rd = {24'h0, leds_q};
    end

    load_align u_load_align (
        .word_i   (mem_rdata_i),
        .off_i    (addr_q[1:0]),
        .funct3_i (f3_q),
        .data_o   (ld_data)
    );

    // The request cycle itself counts as the first stall cycle, so ACCESS
    // lasts WAIT_STATES cycles (at least one, which carries the write strobe).
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        stall_o    = 1'b0;
        err_o      = 1'b0;
        rdata_o    = 32'h0;
        mem_we_o   = 1'b0;
        mem_be_o   = 4'b0000;
        mem_addr_o = addr_q[ADDR_W+1:2];
        case (state_q)
            IDLE: begin
                mem_addr_o = addr_i[ADDR_W+1:2];
                if (req_i && misal)
                    err_o = 1'b1;
                else if (mmio_acc && !we_i)
                    rdata_o = mmio_rd;
                if (start_ram) begin
                    stall_o = 1'b1;
                    state_d = ACCESS;
                    wait_d  = WS;
                end
            end
            ACCESS: begin
                stall_o = 1'b1;
                if (we_q) mem_be_o = be_q;
                if (wait_q == WS) mem_we_o = we_q;
                if (wait_q <= 3'd1) state_d = DONE;
                else                wait_d  = wait_q - 3'd1;
            end
            DONE: begin
                if (!we_q) rdata_o = ld_data;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            wait_q  <= 3'd0;
            cyc_q   <= 32'h0;
            stc_q   <= 32'h0;
            leds_q  <= 8'h0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cyc_q   <= cyc_q + 32'd1;
            if (state_q == DONE && we_q)
                stc_q <= stc_q + 32'd1;
            if (mmio_acc && we_i && mmio_off == MMIO_LEDS)
                leds_q <= wdata_i[7:0];
        end
    end

    // Request capture: the M-stage inputs are only trusted in the request cycle.
    always_ff @(posedge clk_i) begin
        if (start_ram) begin
            addr_q  <= addr_i[ADDR_W+1:0];
            we_q    <= we_i;
            f3_q    <= funct3_i;
            wdata_q <= lane_data(funct3_i, wdata_i);
            be_q    <= byte_en(funct3_i, addr_i[1:0]);
        end
    end

    assign mem_wdata_o = wdata_q;
    assign leds_o      = leds_q;

endmodule
